controle_pc: RTL and testbench
==============================

# controle_pc

Sequencer for the processor's program counter and instruction-fetch path. Holds the PC register, handshakes each fetch with instruction memory, issues one commit pulse per instruction, and loads the next PC from PC+4, the branch target produced by the branch adder, the jump target or the register (jr) target. It sits between the main control decoder, the branch adder and instruction memory, and turns the monocycle datapath into a handshaked fetch/execute sequence.

## Interface
Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, redirect address for a misaligned target; used only with CONTROLE_PC_EXCECAO_EN.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- busca_ack  input  1  instruction memory: instruction word valid this cycle.
- desvio_tomado  input  1  branch taken (branch & condition), from control.
- endereco_jump  input  32  branch target from the branch adder.
- jump  input  1  j/jal instruction.
- indice_jump  input  26  instruction bits [25:0].
- jr  input  1  jr instruction.
- endereco_jr  input  32  register-file read value for jr.
- halt  input  1  halt instruction decoded.
- endereco_PC  output  32  current PC, to instruction memory and the branch adder.
- pc_mais_4  output  32  endereco_PC + 4, modulo 2^32.
- busca_req  output  1  fetch request.
- instr_valida  output  1  commit strobe; gates register-file and data-memory writes.
- parado  output  1  processor halted.
- contador_instr  output  32  count of committed instructions.

## Operation
- FSM states: INICIO, BUSCA, EXECUTA, PARADO.
- INICIO: all strobes low. Moves to BUSCA on the next edge.
- BUSCA: busca_req=1. Stays in BUSCA while busca_ack=0. Moves to EXECUTA on an edge where busca_ack=1.
- EXECUTA: instr_valida=1 and busca_req=0. Control inputs are sampled on the edge that leaves EXECUTA.
  - halt=1: the PC is held and the FSM goes to PARADO.
  - halt=0: the PC loads the next-PC value and the FSM goes to BUSCA.
- Next-PC priority: jr → endereco_jr; jump → {pc_mais_4[31:28], indice_jump, 2'b00}; desvio_tomado → endereco_jump; otherwise pc_mais_4. The priority applies even if several selects are high.
- contador_instr increments on every edge leaving EXECUTA, including halt. It wraps from 32'hFFFF_FFFF to 0.
- PARADO: parado=1. All inputs are ignored. Only reset exits this state.
- busca_ack is ignored outside BUSCA.
- Without the macro, bits [1:0] of the selected target are forced to 2'b00.

## Timing
- Reset values: endereco_PC=RESET_ADDR, pc_mais_4=RESET_ADDR+4, busca_req=0, instr_valida=0, parado=0, contador_instr=0, state INICIO.
- Asserting reset_n low at any time forces the reset values immediately. Any in-flight fetch is abandoned.
- First busca_req: the first cycle after the first rising edge with reset_n high.
- Minimum 2 cycles per instruction (ack in the first BUSCA cycle). Each wait cycle adds exactly 1 cycle.
- endereco_PC is stable throughout BUSCA and EXECUTA. It changes only on the edge leaving EXECUTA.
- pc_mais_4 is combinational from endereco_PC. 32'hFFFF_FFFC + 4 = 0.
- instr_valida is high for exactly one cycle per instruction and is never high in the same cycle as busca_req.

## Configuration
- CONTROLE_PC_EXCECAO_EN: adds output excecao (1) and output epc (32), both reset to 0.
- With the macro, a selected jr/jump/branch target with bits [1:0] ≠ 0 triggers an exception on the edge leaving EXECUTA:
  - endereco_PC ← EXC_VECTOR;
  - epc ← address of the faulting instruction;
  - excecao is pulsed high for the following cycle;
  - contador_instr still increments.
- halt overrides the exception check.
- Without the macro, the ports are absent and the low target bits are masked.

## Test plan
- Reset and sequential run: release reset, busca_ack=1 always → PC sequence 0, 4, 8, 12 at 2 cycles each; contador_instr=3 when PC=12.
- Fetch wait: busca_ack low for 3 BUSCA cycles → busca_req high 4 cycles, then instr_valida high 1 cycle, PC unchanged until then.
- Redirect priority: PC=0x100, jr=1 with endereco_jr=0x400, jump=1, desvio_tomado=1 → next PC 0x400. With jump only and indice_jump=0x10 → next PC 0x40. With branch only and endereco_jump=0x200 → next PC 0x200.
- Halt: halt=1 in EXECUTA at PC=0x20 → parado=1, PC stays 0x20, busca_req stays 0 for 10 cycles, contador increments once.
- Async reset mid-fetch: reset_n low during BUSCA at PC=0x40 → outputs return to reset values before the next edge; restart fetch from RESET_ADDR.
- Macro on, misaligned target: endereco_jr=0x402 at PC=0x10 → PC=0x80, epc=0x10, excecao high 1 cycle. Macro off, same stimulus → PC=0x400.

Source files
------------

// File: rtl/controle_pc.sv
`default_nettype none
// ============================================================================
// Module   : controle_pc
// Purpose  : PC register and handshaked fetch/execute sequencer with
//            jr/jump/branch redirect. Optional misaligned-target exception
//            enabled by CONTROLE_PC_EXCECAO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module controle_pc #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        busca_ack,
    input  logic        desvio_tomado,
    input  logic [31:0] endereco_jump,
    input  logic        jump,
    input  logic [25:0] indice_jump,
    input  logic        jr,
    input  logic [31:0] endereco_jr,
    input  logic        halt,
    output logic [31:0] endereco_PC,
    output logic [31:0] pc_mais_4,
    output logic        busca_req,
    output logic        instr_valida,
    output logic        parado,
    output logic [31:0] contador_instr
`ifdef CONTROLE_PC_EXCECAO_EN
    ,
    output logic        excecao,
    output logic [31:0] epc
`endif
);

    typedef enum logic [1:0] {
        INICIO  = 2'd0,
        BUSCA   = 2'd1,
        EXECUTA = 2'd2,
        PARADO  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] next_pc;

    assign endereco_PC    = pc_q;
    assign pc_mais_4      = pc_q + 32'd4;
    assign busca_req      = (state_q == BUSCA);
    assign instr_valida   = (state_q == EXECUTA);
    assign parado         = (state_q == PARADO);
    assign contador_instr = cnt_q;

    // Fixed redirect priority: jr, then jump, then taken branch.
    always_comb begin
        redirect = jr | jump | desvio_tomado;
        target   = endereco_jump;
        if (jr) begin
            target = endereco_jr;
        end else if (jump) begin
            target = {pc_mais_4[31:28], indice_jump, 2'b00};
        end
    end

`ifdef CONTROLE_PC_EXCECAO_EN
    logic        exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic        misaligned;

    assign misaligned = redirect && (target[1:0] != 2'b00);
    assign next_pc    = misaligned ? EXC_VECTOR : (redirect ? target : pc_mais_4);
    assign excecao    = exc_q;
    assign epc        = epc_q;
`else
    logic [31:0] exc_vector_unused;

    assign exc_vector_unused = EXC_VECTOR;
    assign next_pc = redirect ? (target & ~32'h3) : pc_mais_4;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
`ifdef CONTROLE_PC_EXCECAO_EN
        exc_d   = 1'b0;
        epc_d   = epc_q;
`endif
        case (state_q)
            INICIO:  state_d = BUSCA;
            BUSCA:   if (busca_ack) state_d = EXECUTA;
            EXECUTA: begin
                cnt_d = cnt_q + 32'd1;
                if (halt) begin
                    state_d = PARADO;
                end else begin
                    state_d = BUSCA;
                    pc_d    = next_pc;
`ifdef CONTROLE_PC_EXCECAO_EN
                    if (misaligned) begin
                        exc_d = 1'b1;
                        epc_d = pc_q;
                    end
`endif
                end
            end
            PARADO:  state_d = PARADO;
            default: state_d = INICIO;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INICIO;
            pc_q    <= RESET_ADDR;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CONTROLE_PC_EXCECAO_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exc_q <= 1'b0;
            epc_q <= 32'd0;
        end else begin
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_controle_pc.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_pc
// Purpose  : Directed self-checking bench for controle_pc with a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controle_pc;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        busca_ack = 1'b0;
    logic        desvio_tomado = 1'b0;
    logic [31:0] endereco_jump = 32'd0;
    logic        jump = 1'b0;
    logic [25:0] indice_jump = 26'd0;
    logic        jr = 1'b0;
    logic [31:0] endereco_jr = 32'd0;
    logic        halt = 1'b0;
    logic [31:0] endereco_PC, pc_mais_4, contador_instr;
    logic        busca_req, instr_valida, parado;
`ifdef CONTROLE_PC_EXCECAO_EN
    logic        excecao;
    logic [31:0] epc;
`endif

    int errors = 0;
    int checks = 0;
    int n_instr = 0;
    int nreq, nval;

    always #5 clock = ~clock;

    controle_pc dut (
        .clock(clock), .reset_n(reset_n), .busca_ack(busca_ack),
        .desvio_tomado(desvio_tomado), .endereco_jump(endereco_jump),
        .jump(jump), .indice_jump(indice_jump), .jr(jr),
        .endereco_jr(endereco_jr), .halt(halt),
        .endereco_PC(endereco_PC), .pc_mais_4(pc_mais_4),
        .busca_req(busca_req), .instr_valida(instr_valida),
        .parado(parado), .contador_instr(contador_instr)
`ifdef CONTROLE_PC_EXCECAO_EN
        , .excecao(excecao), .epc(epc)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 fetching, 2 executing, 3 halted.
    int          m_phase;
    logic [31:0] m_pc, m_cnt, m_epc;
    logic        m_exc;

    function automatic logic [31:0] sel_target(input logic [31:0] pc);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (jr) return endereco_jr;
        if (jump) return {p4[31:28], indice_jump, 2'b00};
        if (desvio_tomado) return endereco_jump;
        return p4;
    endfunction

    function automatic logic faulty(input logic [31:0] pc);
        logic [31:0] t;
        t = sel_target(pc);
        return (jr || jump || desvio_tomado) && (t % 4 != 0);
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pc);
`ifdef CONTROLE_PC_EXCECAO_EN
        if (faulty(pc)) return 32'h0000_0080;
        return sel_target(pc);
`else
        return sel_target(pc) & 32'hFFFF_FFFC;
`endif
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_pc    <= 32'h0;
            m_cnt   <= 32'h0;
            m_exc   <= 1'b0;
            m_epc   <= 32'h0;
        end else begin
            m_exc <= 1'b0;
            case (m_phase)
                0: m_phase <= 1;
                1: if (busca_ack) m_phase <= 2;
                2: begin
                    m_cnt <= m_cnt + 32'd1;
                    if (halt) begin
                        m_phase <= 3;
                    end else begin
                        m_phase <= 1;
                        m_pc    <= model_next(m_pc);
                        if (faulty(m_pc)) begin
                            m_exc <= 1'b1;
                            m_epc <= m_pc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clock) begin
        check("pc", endereco_PC, m_pc);
        check("pc_mais_4", pc_mais_4, m_pc + 32'd4);
        check("busca_req", {31'd0, busca_req}, {31'd0, m_phase == 1});
        check("instr_valida", {31'd0, instr_valida}, {31'd0, m_phase == 2});
        check("parado", {31'd0, parado}, {31'd0, m_phase == 3});
        check("contador", contador_instr, m_cnt);
`ifdef CONTROLE_PC_EXCECAO_EN
        check("excecao", {31'd0, excecao}, {31'd0, m_exc});
        check("epc", epc, m_epc);
`endif
    end

    // Starts 2 time units into a BUSCA cycle; ends likewise in the next state.
    task automatic instr(input int waits, input logic j_r, input logic [31:0] e_jr,
                         input logic j, input logic [25:0] idx, input logic br,
                         input logic [31:0] e_br, input logic h);
        nreq = 0;
        nval = 0;
        busca_ack = 1'b0;
        for (int i = 0; i < waits; i++) begin
            nreq += int'(busca_req);
            nval += int'(instr_valida);
            @(posedge clock); #2;
        end
        busca_ack = 1'b1;
        nreq += int'(busca_req);
        nval += int'(instr_valida);
        @(posedge clock); #2;
        busca_ack = 1'b0;
        jr = j_r; endereco_jr = e_jr; jump = j; indice_jump = idx;
        desvio_tomado = br; endereco_jump = e_br; halt = h;
        nreq += int'(busca_req);
        nval += int'(instr_valida);
        @(posedge clock); #2;
        jr = 1'b0; jump = 1'b0; desvio_tomado = 1'b0; halt = 1'b0;
        n_instr++;
    endtask

    task automatic seq();
        instr(0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic go_jr(input logic [31:0] a);
        instr(0, 1'b1, a, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_pc", endereco_PC, 32'h0);
        check("rst_pc4", pc_mais_4, 32'h4);
        check("rst_req", {31'd0, busca_req}, 32'd0);
        #1 reset_n = 1'b1;
        @(posedge clock); #2;
        check("first_req", {31'd0, busca_req}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            seq();
            check("seq_pc", endereco_PC, 32'(4 * (i + 1)));
            check("seq_req_cycles", 32'(nreq), 32'd1);
        end
        check("cnt_at_12", contador_instr, 32'd3);

        instr(3, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0);
        check("wait_req_cycles", 32'(nreq), 32'd4);
        check("wait_val_cycles", 32'(nval), 32'd1);
        check("wait_pc", endereco_PC, 32'h10);

        go_jr(32'h100);
        check("jr_pc", endereco_PC, 32'h100);
        instr(0, 1'b1, 32'h400, 1'b1, 26'h10, 1'b1, 32'h200, 1'b0);
        check("prio_all", endereco_PC, 32'h400);
        instr(0, 1'b0, 32'h0, 1'b1, 26'h10, 1'b0, 32'h200, 1'b0);
        check("prio_jump", endereco_PC, 32'h40);
        instr(0, 1'b0, 32'h0, 1'b0, 26'h10, 1'b1, 32'h200, 1'b0);
        check("prio_branch", endereco_PC, 32'h200);

        go_jr(32'h10);
        go_jr(32'h402);
`ifdef CONTROLE_PC_EXCECAO_EN
        check("exc_pc", endereco_PC, 32'h80);
        check("exc_epc", epc, 32'h10);
        check("exc_pulse", {31'd0, excecao}, 32'd1);
        @(posedge clock); #2;
        check("exc_clear", {31'd0, excecao}, 32'd0);
`else
        check("mask_pc", endereco_PC, 32'h400);
`endif

        go_jr(32'hFFFF_FFFC);
        check("wrap_pc4", pc_mais_4, 32'h0);
        seq();
        check("wrap_pc", endereco_PC, 32'h0);

        go_jr(32'h20);
        instr(0, 1'b0, 32'h0, 1'b0, 26'd0, 1'b0, 32'h0, 1'b1);
        check("halt_parado", {31'd0, parado}, 32'd1);
        check("halt_pc", endereco_PC, 32'h20);
        check("halt_cnt", contador_instr, 32'(n_instr));
        busca_ack = 1'b1; jr = 1'b1; endereco_jr = 32'h300;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #2;
            check("halt_req", {31'd0, busca_req}, 32'd0);
            check("halt_hold_pc", endereco_PC, 32'h20);
        end
        check("halt_cnt_hold", contador_instr, 32'(n_instr));
        busca_ack = 1'b0; jr = 1'b0;

        reset_n = 1'b0;
        #1;
        check("areset_parado", {31'd0, parado}, 32'd0);
        @(posedge clock); #2 reset_n = 1'b1;
        @(posedge clock); #2;
        n_instr = 0;
        go_jr(32'h40);
        check("pre_abort_pc", endereco_PC, 32'h40);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        check("abort_pc", endereco_PC, 32'h0);
        check("abort_pc4", pc_mais_4, 32'h4);
        check("abort_req", {31'd0, busca_req}, 32'd0);
        check("abort_cnt", contador_instr, 32'd0);
        @(posedge clock); #1 reset_n = 1'b1;
        @(posedge clock); #2;
        check("restart_req", {31'd0, busca_req}, 32'd1);
        seq();
        check("restart_pc", endereco_PC, 32'h4);

        @(posedge clock); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
